// File: rtl/temp_lcd_pkg.sv
// Shared constants, types and helpers for the temperature-to-LCD formatter.
// Contents: raw/intermediate widths, ASCII character codes, formatter state
// encoding, the registered display payload and double-dabble helpers.
package temp_lcd_pkg;

    localparam int unsigned RAW_W      = 12;          // raw two's-complement reading
    localparam int unsigned MAG_W      = RAW_W + 1;   // magnitude, holds +2048
    localparam int unsigned PROD_W     = 16;          // mag*10 plus rounding term
    localparam int unsigned TENTHS_W   = 11;          // clamped tenths of a degree
    localparam int unsigned BCD_W      = 16;          // four BCD nibbles H,T,U,F
    localparam int unsigned CONV_ITER  = 11;          // one shift per tenths bit
    localparam int unsigned ITER_CNT_W = 4;
    localparam int unsigned CHAR_W     = 8;
    localparam int unsigned OVF_TENTHS = 1000;        // -100.0 and below cannot fit

    localparam logic [CHAR_W-1:0] CH_SPACE = 8'h20;
    localparam logic [CHAR_W-1:0] CH_DASH  = 8'h2D;
    localparam logic [CHAR_W-1:0] CH_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CONV = 2'd2,
        LOAD = 2'd3
    } state_t;

    // Everything the LOAD cycle writes into the output registers.
    typedef struct packed {
        logic [CHAR_W-1:0] digit0;
        logic [CHAR_W-1:0] digit1;
        logic [CHAR_W-1:0] digit2;
        logic [CHAR_W-1:0] digit3;
        logic              dec_pt2;
        logic              ovf;
    } lcd_fmt_t;

    // Double-dabble correction: add 3 to every nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < int'(BCD_W / 4); i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // BCD nibble to ASCII digit.
    function automatic logic [CHAR_W-1:0] bcd_char(input logic [3:0] n);
        return CH_ZERO + CHAR_W'(n);
    endfunction

endpackage

// File: rtl/temp2lcd_fmt_if.sv
// Raw-reading handshake between a producer (software shim or I2C poller)
// and the formatter.
//   temp_valid : producer offers temp_raw
//   temp_ready : formatter can accept (only while idle)
//   temp_raw   : 12-bit two's-complement reading
// A transfer happens on a clock edge where temp_valid && temp_ready.
interface temp2lcd_fmt_if;
    import temp_lcd_pkg::*;

    logic             temp_valid;
    logic             temp_ready;
    logic [RAW_W-1:0] temp_raw;

    modport master (
        output temp_valid,
        output temp_raw,
        input  temp_ready
    );

    modport slave (
        input  temp_valid,
        input  temp_raw,
        output temp_ready
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 11-bit binary to 4-digit BCD converter (double-dabble, one bit
// per clock).
//   sys_clk, rst : clock, synchronous active-high reset
//   start        : load bin and begin; restarts a conversion in flight
//   bin          : binary value, sampled on the start edge
//   last_c       : high during the cycle whose edge performs the final shift
//   done         : one-cycle pulse, bcd valid while it is high and after
//   bcd          : {hundreds, tens, units, tenths} nibbles
module bin2bcd_seq
    import temp_lcd_pkg::*;
(
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TENTHS_W-1:0] bin,
    output logic                last_c,
    output logic                done,
    output logic [BCD_W-1:0]    bcd
);

    localparam int unsigned SR_W = BCD_W + TENTHS_W;

    logic [SR_W-1:0]       sr;
    logic [ITER_CNT_W-1:0] cnt;
    logic                  busy;
    logic [BCD_W-1:0]      adj_c;

    // Correct the BCD half before it is shifted.
    always_comb begin
        adj_c = dd_adjust(sr[SR_W-1 -: BCD_W]);
    end

    assign last_c = busy && (cnt == ITER_CNT_W'(CONV_ITER - 1));
    assign bcd    = sr[SR_W-1 -: BCD_W];

    // Shift register {bcd, bin} shifts left once per clock while busy.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr   <= {{BCD_W{1'b0}}, bin};
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                sr  <= {adj_c[BCD_W-2:0], sr[TENTHS_W-1:0], 1'b0};
                cnt <= cnt + ITER_CNT_W'(1);
                if (last_c) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/temp2lcd_fmt.sv
// Raw temperature word to four LCD characters, one decimal, degrees C.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   temp_if            : raw-reading handshake (slave side)
//   LCD_digit0..3      : ASCII characters, left to right
//   LCD_decPt0..2      : decimal point after the matching digit
//   LCD_colon          : colon segment, never lit
//   ovf                : last reading could not be displayed
//   done               : one-cycle pulse when the outputs update
// Flow per reading: IDLE -> PREP -> CONV (11 clocks) -> LOAD -> IDLE.
// Outputs only change on the LOAD edge (or reset) so the slower LCD domain
// always samples a stable, coherent set.
module temp2lcd_fmt
    import temp_lcd_pkg::*;
#(
    parameter int unsigned FRAC_BITS     = 4,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    temp2lcd_fmt_if.slave     temp_if,
    output logic [CHAR_W-1:0] LCD_digit0,
    output logic [CHAR_W-1:0] LCD_digit1,
    output logic [CHAR_W-1:0] LCD_digit2,
    output logic [CHAR_W-1:0] LCD_digit3,
    output logic              LCD_decPt0,
    output logic              LCD_decPt1,
    output logic              LCD_decPt2,
    output logic              LCD_colon,
    output logic              ovf,
    output logic              done
);

    localparam int unsigned ROUND_ADD  = (FRAC_BITS > 0) ? (1 << (FRAC_BITS - 1)) : 0;
    localparam int unsigned TENTHS_MAX = (1 << TENTHS_W) - 1;

    state_t              state;
    logic                ready_q;
    logic [RAW_W-1:0]    raw_q;
    logic                neg_q;
    logic [TENTHS_W-1:0] tenths_q;

    logic [MAG_W-1:0]    ext_c;
    logic [MAG_W-1:0]    mag_c;
    logic [PROD_W-1:0]   prod_c;
    logic [PROD_W-1:0]   round_c;
    logic [PROD_W-1:0]   shifted_c;
    logic [TENTHS_W-1:0] tenths_c;
    logic                start_c;

    logic                bcd_last_c;
    logic                bcd_done;
    logic [BCD_W-1:0]    bcd;
    logic [3:0]          bcd_h_c;
    logic [3:0]          bcd_t_c;
    logic [3:0]          bcd_u_c;
    logic [3:0]          bcd_f_c;
    logic [CHAR_W-1:0]   lead_c;
    lcd_fmt_t            fmt_c;

    assign temp_if.temp_ready = ready_q;
    assign start_c            = (state == PREP);

    // Magnitude, scale to tenths with round-half-up, clamp to converter width.
    // Sign-extending to 13 bits lets -2048 become +2048 without wrapping.
    always_comb begin
        ext_c     = {raw_q[RAW_W-1], raw_q};
        mag_c     = raw_q[RAW_W-1] ? (MAG_W'(0) - ext_c) : ext_c;
        prod_c    = (PROD_W'(mag_c) << 3) + (PROD_W'(mag_c) << 1);
        round_c   = prod_c + PROD_W'(ROUND_ADD);
        shifted_c = round_c >> FRAC_BITS;
        tenths_c  = (shifted_c > PROD_W'(TENTHS_MAX)) ? TENTHS_W'(TENTHS_MAX)
                                                      : shifted_c[TENTHS_W-1:0];
    end

    bin2bcd_seq u_bin2bcd (
        .sys_clk (wb_clk_i),
        .rst     (wb_rst_i),
        .start   (start_c),
        .bin     (tenths_c),
        .last_c  (bcd_last_c),
        .done    (bcd_done),
        .bcd     (bcd)
    );

    assign bcd_h_c = bcd[15:12];
    assign bcd_t_c = bcd[11:8];
    assign bcd_u_c = bcd[7:4];
    assign bcd_f_c = bcd[3:0];

    // Character mapping; the default is the all-dash overflow pattern.
    always_comb begin
        lead_c        = ((bcd_t_c == 4'd0) && BLANK_LEADING) ? CH_SPACE : bcd_char(bcd_t_c);
        fmt_c.digit0  = CH_DASH;
        fmt_c.digit1  = CH_DASH;
        fmt_c.digit2  = CH_DASH;
        fmt_c.digit3  = CH_DASH;
        fmt_c.dec_pt2 = 1'b0;
        fmt_c.ovf     = 1'b1;
        if (!(neg_q && (tenths_q >= TENTHS_W'(OVF_TENTHS)))) begin
            fmt_c.ovf     = 1'b0;
            fmt_c.dec_pt2 = 1'b1;
            fmt_c.digit2  = bcd_char(bcd_u_c);
            fmt_c.digit3  = bcd_char(bcd_f_c);
            if (neg_q) begin
                fmt_c.digit0 = CH_DASH;
                fmt_c.digit1 = lead_c;
            end else if (bcd_h_c != 4'd0) begin
                fmt_c.digit0 = bcd_char(bcd_h_c);
                fmt_c.digit1 = bcd_char(bcd_t_c);
            end else begin
                fmt_c.digit0 = CH_SPACE;
                fmt_c.digit1 = lead_c;
            end
        end
    end

    // Formatter FSM with registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            ready_q    <= 1'b1;
            raw_q      <= '0;
            neg_q      <= 1'b0;
            tenths_q   <= '0;
            LCD_digit0 <= CH_DASH;
            LCD_digit1 <= CH_DASH;
            LCD_digit2 <= CH_DASH;
            LCD_digit3 <= CH_DASH;
            LCD_decPt0 <= 1'b0;
            LCD_decPt1 <= 1'b0;
            LCD_decPt2 <= 1'b0;
            LCD_colon  <= 1'b0;
            ovf        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (temp_if.temp_valid && ready_q) begin
                        raw_q   <= temp_if.temp_raw;
                        ready_q <= 1'b0;
                        state   <= PREP;
                    end
                end
                PREP: begin
                    // A reading that rounds to 0.0 is shown unsigned.
                    tenths_q <= tenths_c;
                    neg_q    <= raw_q[RAW_W-1] && (tenths_c != '0);
                    state    <= CONV;
                end
                CONV: begin
                    if (bcd_last_c) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (bcd_done) begin
                        LCD_digit0 <= fmt_c.digit0;
                        LCD_digit1 <= fmt_c.digit1;
                        LCD_digit2 <= fmt_c.digit2;
                        LCD_digit3 <= fmt_c.digit3;
                        LCD_decPt0 <= 1'b0;
                        LCD_decPt1 <= 1'b0;
                        LCD_decPt2 <= fmt_c.dec_pt2;
                        LCD_colon  <= 1'b0;
                        ovf        <= fmt_c.ovf;
                        done       <= 1'b1;
                        ready_q    <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp2lcd_fmt.sv
// Directed bench for temp2lcd_fmt: reset state, positive/negative formatting,
// overflow and its clearing, back-to-back handshake and reset mid-conversion.
module tb_temp2lcd_fmt;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [7:0] d0, d1, d2, d3;
    logic       dp0, dp1, dp2, colon, ovf, done;

    int n_checks = 0;
    int n_errors = 0;

    temp2lcd_fmt_if tif ();

    temp2lcd_fmt #(
        .FRAC_BITS     (4),
        .BLANK_LEADING (1'b1)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .temp_if    (tif),
        .LCD_digit0 (d0),
        .LCD_digit1 (d1),
        .LCD_digit2 (d2),
        .LCD_digit3 (d3),
        .LCD_decPt0 (dp0),
        .LCD_decPt1 (dp1),
        .LCD_decPt2 (dp2),
        .LCD_colon  (colon),
        .ovf        (ovf),
        .done       (done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    localparam logic [36:0] DISP_DASH = {8'h2D, 8'h2D, 8'h2D, 8'h2D, 5'b00000};

    // Observed display: {digit0..3, dp0, dp1, dp2, colon, ovf}.
    function automatic logic [36:0] disp();
        return {d0, d1, d2, d3, dp0, dp1, dp2, colon, ovf};
    endfunction

    function automatic logic [36:0] mk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] e,
                                       input logic p2, input logic ov);
        return {a, b, c, e, 1'b0, 1'b0, p2, 1'b0, ov};
    endfunction

    // Offer one raw word for exactly one edge; returns #1 after that edge.
    task automatic accept(input logic [11:0] raw);
        tif.temp_raw   = raw;
        tif.temp_valid = 1'b1;
        @(posedge wb_clk_i);
        #1;
        tif.temp_valid = 1'b0;
    endtask

    // Edges until done is seen (sampled #1 after each edge); -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge wb_clk_i);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        wb_rst_i       = 1'b1;
        tif.temp_valid = 1'b0;
        tif.temp_raw   = '0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        n_checks++;
        if (disp() !== DISP_DASH) begin
            n_errors++;
            $display("FAIL reset_display: got %h expected %h", disp(), DISP_DASH);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        n_checks++;
        if (tif.temp_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 1", tif.temp_ready);
        end
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        n_checks++;
        if (disp() !== DISP_DASH || tif.temp_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_idle: got %h/%b expected %h/1", disp(), tif.temp_ready, DISP_DASH);
        end
    endtask

    task automatic test_positive();
        logic [11:0] raws[3];
        logic [36:0] exps[3];
        int lat;
        raws[0] = 12'h190; exps[0] = mk(8'h20, 8'h32, 8'h35, 8'h30, 1'b1, 1'b0); //  25.0
        raws[1] = 12'h7FF; exps[1] = mk(8'h31, 8'h32, 8'h37, 8'h39, 1'b1, 1'b0); // 127.9
        raws[2] = 12'h001; exps[2] = mk(8'h20, 8'h20, 8'h30, 8'h31, 1'b1, 1'b0); //   0.1
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (tif.temp_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL pos_ready_before[%0d]: got %b expected 1", i, tif.temp_ready);
            end
            accept(raws[i]);
            n_checks++;
            if (tif.temp_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL pos_ready_busy[%0d]: got %b expected 0", i, tif.temp_ready);
            end
            wait_done(lat);
            n_checks++;
            if (lat !== 13) begin
                n_errors++;
                $display("FAIL pos_latency[%0d]: got %0d expected 13", i, lat);
            end
            n_checks++;
            if (disp() !== exps[i]) begin
                n_errors++;
                $display("FAIL pos_display[%0d] raw %h: got %h expected %h", i, raws[i], disp(), exps[i]);
            end
            @(posedge wb_clk_i);
            #1;
            n_checks++;
            if (done !== 1'b0 || disp() !== exps[i] || tif.temp_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL pos_after_load[%0d]: got done=%b disp=%h ready=%b expected done=0 disp=%h ready=1",
                         i, done, disp(), tif.temp_ready, exps[i]);
            end
        end
    endtask

    task automatic test_negative();
        logic [11:0] raws[3];
        logic [36:0] exps[3];
        int lat;
        raws[0] = 12'hE70; exps[0] = mk(8'h2D, 8'h32, 8'h35, 8'h30, 1'b1, 1'b0); // -25.0
        raws[1] = 12'hFFF; exps[1] = mk(8'h2D, 8'h20, 8'h30, 8'h31, 1'b1, 1'b0); // - 0.1
        raws[2] = 12'h9C2; exps[2] = mk(8'h2D, 8'h39, 8'h39, 8'h39, 1'b1, 1'b0); // -99.9
        for (int i = 0; i < 3; i++) begin
            accept(raws[i]);
            wait_done(lat);
            n_checks++;
            if (lat !== 13) begin
                n_errors++;
                $display("FAIL neg_latency[%0d]: got %0d expected 13", i, lat);
            end
            n_checks++;
            if (disp() !== exps[i]) begin
                n_errors++;
                $display("FAIL neg_display[%0d] raw %h: got %h expected %h", i, raws[i], disp(), exps[i]);
            end
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic test_overflow();
        logic [11:0] raws[3];
        logic [36:0] exps[3];
        int lat;
        raws[0] = 12'h800; exps[0] = {8'h2D, 8'h2D, 8'h2D, 8'h2D, 5'b00001};        // -128.0
        raws[1] = 12'h9C0; exps[1] = {8'h2D, 8'h2D, 8'h2D, 8'h2D, 5'b00001};        // -100.0
        raws[2] = 12'h0A0; exps[2] = mk(8'h20, 8'h31, 8'h30, 8'h30, 1'b1, 1'b0);    //   10.0
        for (int i = 0; i < 3; i++) begin
            accept(raws[i]);
            wait_done(lat);
            n_checks++;
            if (lat !== 13) begin
                n_errors++;
                $display("FAIL ovf_latency[%0d]: got %0d expected 13", i, lat);
            end
            n_checks++;
            if (disp() !== exps[i]) begin
                n_errors++;
                $display("FAIL ovf_display[%0d] raw %h: got %h expected %h", i, raws[i], disp(), exps[i]);
            end
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        accept(12'h190);                       // edge N
        repeat (4) @(posedge wb_clk_i);
        #1;
        n_checks++;
        if (tif.temp_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_ready_busy: got %b expected 0", tif.temp_ready);
        end
        accept(12'h050);                       // edge N+5, must be ignored
        wait_done(lat);
        n_checks++;
        if (lat !== 8) begin
            n_errors++;
            $display("FAIL b2b_latency_first: got %0d expected 8", lat);
        end
        n_checks++;
        if (disp() !== mk(8'h20, 8'h32, 8'h35, 8'h30, 1'b1, 1'b0)) begin
            n_errors++;
            $display("FAIL b2b_display_first: got %h expected %h", disp(), mk(8'h20, 8'h32, 8'h35, 8'h30, 1'b1, 1'b0));
        end
        n_checks++;
        if (tif.temp_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_ready_return: got %b expected 1", tif.temp_ready);
        end
        accept(12'h050);                       // first possible accept
        wait_done(lat);
        n_checks++;
        if (lat !== 13) begin
            n_errors++;
            $display("FAIL b2b_latency_second: got %0d expected 13", lat);
        end
        n_checks++;
        if (disp() !== mk(8'h20, 8'h20, 8'h35, 8'h30, 1'b1, 1'b0)) begin
            n_errors++;
            $display("FAIL b2b_display_second: got %h expected %h", disp(), mk(8'h20, 8'h20, 8'h35, 8'h30, 1'b1, 1'b0));
        end
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_reset_mid();
        int n_done;
        accept(12'h190);                       // edge N
        repeat (5) @(posedge wb_clk_i);
        #1;
        wb_rst_i       = 1'b1;                 // sampled at N+6, with a competing offer
        tif.temp_valid = 1'b1;
        tif.temp_raw   = 12'h190;
        @(posedge wb_clk_i);
        #1;
        wb_rst_i       = 1'b0;
        tif.temp_valid = 1'b0;
        n_checks++;
        if (disp() !== DISP_DASH || done !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs: got %h done=%b expected %h done=0", disp(), done, DISP_DASH);
        end
        @(posedge wb_clk_i);
        #1;
        n_checks++;
        if (tif.temp_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_ready: got %b expected 1", tif.temp_ready);
        end
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) n_done++;
            @(posedge wb_clk_i);
            #1;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_errors++;
            $display("FAIL rst_mid_no_done: got %0d pulses expected 0", n_done);
        end
        n_checks++;
        if (disp() !== DISP_DASH) begin
            n_errors++;
            $display("FAIL rst_mid_held: got %h expected %h", disp(), DISP_DASH);
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
